// File: rtl/operand_loader_pkg.sv
`default_nettype none
// operand_loader_pkg: shared state encoding, widths and latency default for the operand loader.
// Rev 1.0
package operand_loader_pkg;

  localparam int LAT_DEFAULT = 3;
  localparam int BYTE_W      = 8;
  localparam int OPND_W      = 16;
  localparam int RES_W       = OPND_W + 1;

  typedef enum logic [2:0] {
    LOAD_A0 = 3'd0,
    LOAD_A1 = 3'd1,
    LOAD_B0 = 3'd2,
    LOAD_B1 = 3'd3,
    WAIT    = 3'd4,
    OUT     = 3'd5
  } state_e;

  function automatic logic is_load(input state_e s);
    return (s == LOAD_A0) || (s == LOAD_A1) || (s == LOAD_B0) || (s == LOAD_B1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/operand_loader_if.sv
`default_nettype none
// operand_loader_if: byte stream in, adder operand/result bus, and result handshake.
// Rev 1.0
interface operand_loader_if;
  import operand_loader_pkg::*;

  logic [BYTE_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              in_sof;
  logic              in_cin;
  logic [OPND_W-1:0] ain;
  logic [OPND_W-1:0] bin;
  logic              cin;
  logic [OPND_W-1:0] sout;
  logic              cout;
  logic              res_valid;
  logic [RES_W-1:0]  res_data;
  logic              res_ready;

  // Loader side.
  modport slave (
    input  in_data, in_valid, in_sof, in_cin, sout, cout, res_ready,
    output in_ready, ain, bin, cin, res_valid, res_data
  );

  // Producer / adder / consumer side.
  modport master (
    output in_data, in_valid, in_sof, in_cin, sout, cout, res_ready,
    input  in_ready, ain, bin, cin, res_valid, res_data
  );

endinterface
`default_nettype wire

// File: rtl/operand_loader.sv
`default_nettype none
// operand_loader: assembles two 16-bit operands from a byte stream, drives an external adder
// and captures its result LAT edges after the operand update. Rev 1.0
module operand_loader
  import operand_loader_pkg::*;
#(
  parameter int LAT = LAT_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  operand_loader_if.slave bus
);

  localparam int              CNT_W    = $clog2(LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BYTE_W-1:0] a_lo_q, a_lo_d;
  logic [BYTE_W-1:0] a_hi_q, a_hi_d;
  logic [BYTE_W-1:0] b_lo_q, b_lo_d;
  logic [OPND_W-1:0] ain_q, ain_d;
  logic [OPND_W-1:0] bin_q, bin_d;
  logic              cin_q, cin_d;
  logic [RES_W-1:0]  res_data_q, res_data_d;
  logic              res_valid_q, res_valid_d;
  logic              in_ready_q, in_ready_d;
  logic              xfer;

  assign xfer = bus.in_valid && in_ready_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    a_lo_d     = a_lo_q;
    a_hi_d     = a_hi_q;
    b_lo_d     = b_lo_q;
    ain_d      = ain_q;
    bin_d      = bin_q;
    cin_d      = cin_q;
    res_data_d = res_data_q;

    case (state_q)
      LOAD_A0, LOAD_A1, LOAD_B0, LOAD_B1: begin
        if (xfer) begin
          // A start-of-frame byte always restarts the frame, whatever was collected so far.
          if (bus.in_sof) begin
            a_lo_d  = bus.in_data;
            state_d = LOAD_A1;
          end else begin
            case (state_q)
              LOAD_A0: begin a_lo_d = bus.in_data; state_d = LOAD_A1; end
              LOAD_A1: begin a_hi_d = bus.in_data; state_d = LOAD_B0; end
              LOAD_B0: begin b_lo_d = bus.in_data; state_d = LOAD_B1; end
              default: begin
                ain_d   = {a_hi_q, a_lo_q};
                bin_d   = {bus.in_data, b_lo_q};
                cin_d   = bus.in_cin;
                cnt_d   = CNT_LOAD;
                state_d = WAIT;
              end
            endcase
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          res_data_d = {bus.cout, bus.sout};
          state_d    = OUT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      OUT: begin
        if (bus.res_ready) state_d = LOAD_A0;
      end
      default: state_d = LOAD_A0;
    endcase

    in_ready_d  = is_load(state_d);
    res_valid_d = (state_d == OUT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOAD_A0;
      cnt_q       <= '0;
      a_lo_q      <= '0;
      a_hi_q      <= '0;
      b_lo_q      <= '0;
      ain_q       <= '0;
      bin_q       <= '0;
      cin_q       <= 1'b0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_lo_q      <= a_lo_d;
      a_hi_q      <= a_hi_d;
      b_lo_q      <= b_lo_d;
      ain_q       <= ain_d;
      bin_q       <= bin_d;
      cin_q       <= cin_d;
      res_data_q  <= res_data_d;
      res_valid_q <= res_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.ain       = ain_q;
  assign bus.bin       = bin_q;
  assign bus.cin       = cin_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;

endmodule
`default_nettype wire

// File: tb/tb_operand_loader.sv
`default_nettype none
// tb_operand_loader: directed and randomized frames checked against a frame-level reference model.
// Rev 1.0
module tb_operand_loader;
  import operand_loader_pkg::*;

  localparam int LAT = 3;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  operand_loader_if bus ();

  operand_loader #(.LAT(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Downstream adder: plain 17-bit unsigned sum of the registered operands.
  always_comb begin
    {bus.cout, bus.sout} = {1'b0, bus.ain} + {1'b0, bus.bin} + {{OPND_W{1'b0}}, bus.cin};
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] d, input logic sof, input logic c);
    int n;
    n = 0;
    @(negedge clk);
    bus.in_data  = d;
    bus.in_sof   = sof;
    bus.in_cin   = c;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      checks++; errors++;
      $display("FAIL in_ready_timeout got %0b want 1", bus.in_ready);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    bus.in_cin   = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] a, input logic [15:0] b, input logic c, input logic sof0);
    send_byte(a[7:0],  sof0, 1'b0);
    send_byte(a[15:8], 1'b0, 1'b0);
    send_byte(b[7:0],  1'b0, 1'b0);
    send_byte(b[15:8], 1'b0, c);
  endtask

  // Counts edges after the operand-update edge until res_valid is seen.
  task automatic wait_result(output logic [16:0] data, output int lat);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!bus.res_valid && n < 64);
    if (!bus.res_valid) begin
      checks++; errors++;
      $display("FAIL res_valid_timeout got %0b want 1", bus.res_valid);
    end
    data = bus.res_data;
    lat  = n;
  endtask

  task automatic accept_result(input int delay);
    repeat (delay) @(negedge clk);
    @(negedge clk);
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if ({bus.ain, bus.bin, bus.cin, bus.res_valid, bus.res_data} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got ain=%h bin=%h cin=%b rv=%b rd=%h want all 0",
               bus.ain, bus.bin, bus.cin, bus.res_valid, bus.res_data);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %0b want 1", bus.in_ready);
    end
  endtask

  task automatic test_basic();
    logic [16:0] got;
    int          lat;
    send_byte(8'h34, 1'b0, 1'b0);
    send_byte(8'h12, 1'b0, 1'b0);
    send_byte(8'h78, 1'b0, 1'b0);
    checks++;
    if (bus.ain !== 16'h0000 || bus.bin !== 16'h0000) begin
      errors++;
      $display("FAIL basic_shadow_hold got ain=%h bin=%h want 0000 0000", bus.ain, bus.bin);
    end
    send_byte(8'h56, 1'b0, 1'b0);
    checks++;
    if (bus.ain !== 16'h1234 || bus.bin !== 16'h5678 || bus.cin !== 1'b0 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_operands got ain=%h bin=%h cin=%b rdy=%b want 1234 5678 0 0",
               bus.ain, bus.bin, bus.cin, bus.in_ready);
    end
    wait_result(got, lat);
    checks++;
    if (lat !== LAT || got !== 17'h068AC) begin
      errors++;
      $display("FAIL basic_result got lat=%0d data=%h want lat=%0d data=068ac", lat, got, LAT);
    end
    accept_result(0);
  endtask

  task automatic test_vectors();
    logic [15:0] va [2];
    logic [15:0] vb [2];
    logic        vc [2];
    logic [16:0] ve [2];
    logic [16:0] got;
    int          lat;
    va[0] = 16'hFFFF; vb[0] = 16'h0001; vc[0] = 1'b0; ve[0] = 17'h10000;
    va[1] = 16'hFFFF; vb[1] = 16'hFFFF; vc[1] = 1'b1; ve[1] = 17'h1FFFF;
    for (int i = 0; i < 2; i++) begin
      send_frame(va[i], vb[i], vc[i], 1'b0);
      wait_result(got, lat);
      checks++;
      if (got !== ve[i]) begin
        errors++;
        $display("FAIL vector_%0d got %h want %h", i, got, ve[i]);
      end
      accept_result(0);
    end
  endtask

  task automatic test_backpressure();
    logic [16:0] got;
    int          lat;
    send_frame(16'h0102, 16'h0304, 1'b1, 1'b0);
    wait_result(got, lat);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.res_valid !== 1'b1 || bus.res_data !== 17'h00407 || bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_cycle_%0d got rv=%b rd=%h rdy=%b want 1 00407 0",
                 i, bus.res_valid, bus.res_data, bus.in_ready);
      end
      @(posedge clk);
      #1;
    end
    accept_result(0);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.res_valid !== 1'b0 || bus.ain !== 16'h0102 || bus.bin !== 16'h0304) begin
      errors++;
      $display("FAIL after_accept got rdy=%b rv=%b ain=%h bin=%h want 1 0 0102 0304",
               bus.in_ready, bus.res_valid, bus.ain, bus.bin);
    end
  endtask

  task automatic test_sof_resync();
    logic [16:0] got;
    int          lat;
    int          extra;
    send_byte(8'hAA, 1'b0, 1'b0);
    send_byte(8'hBB, 1'b0, 1'b0);
    send_byte(8'hCC, 1'b0, 1'b0);
    send_byte(8'h01, 1'b1, 1'b0);
    send_byte(8'h00, 1'b0, 1'b0);
    send_byte(8'h02, 1'b0, 1'b0);
    send_byte(8'h00, 1'b0, 1'b0);
    wait_result(got, lat);
    checks++;
    if (got !== 17'h00003) begin
      errors++;
      $display("FAIL sof_result got %h want 00003", got);
    end
    accept_result(0);
    extra = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (bus.res_valid) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL sof_single_result got %0d extra valid cycles want 0", extra);
    end
  endtask

  task automatic test_reset_in_wait();
    logic [16:0] got;
    int          lat;
    int          stray;
    send_frame(16'h1111, 16'h2222, 1'b1, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.ain, bus.bin, bus.cin, bus.res_valid, bus.res_data} !== '0) begin
      errors++;
      $display("FAIL wait_reset_outputs got ain=%h bin=%h cin=%b rv=%b rd=%h want all 0",
               bus.ain, bus.bin, bus.cin, bus.res_valid, bus.res_data);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (bus.res_valid) stray++;
    end
    checks++;
    if (stray != 0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL wait_reset_drop got stray=%0d rdy=%b want 0 1", stray, bus.in_ready);
    end
    send_frame(16'hABCD, 16'h1234, 1'b0, 1'b1);
    wait_result(got, lat);
    checks++;
    if (got !== 17'h0BE01 || lat !== LAT) begin
      errors++;
      $display("FAIL wait_reset_next got %h lat=%0d want 0be01 lat=%0d", got, lat, LAT);
    end
    accept_result(0);
  endtask

  task automatic test_random();
    logic [7:0]  q [$];
    logic [7:0]  d;
    logic [7:0]  stream_d [$];
    logic        stream_s [$];
    logic        stream_c [$];
    logic [15:0] ea, eb;
    logic        ec;
    logic [16:0] exp_res;
    logic [16:0] got;
    int          lat;
    int          np;
    for (int f = 0; f < 25; f++) begin
      stream_d.delete(); stream_s.delete(); stream_c.delete();
      np = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
      for (int k = 0; k < np; k++) begin
        stream_d.push_back(8'($urandom));
        stream_s.push_back(1'b0);
        stream_c.push_back(1'($urandom));
      end
      for (int k = 0; k < 4; k++) begin
        stream_d.push_back(8'($urandom));
        stream_s.push_back((k == 0) ? ((np > 0) ? 1'b1 : 1'($urandom)) : 1'b0);
        stream_c.push_back(1'($urandom));
      end
      q.delete();
      ec = 1'b0;
      foreach (stream_d[i]) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        d = stream_d[i];
        send_byte(d, stream_s[i], stream_c[i]);
        if (stream_s[i]) q.delete();
        q.push_back(d);
        if (q.size() == 4) ec = stream_c[i];
      end
      ea = {q[1], q[0]};
      eb = {q[3], q[2]};
      exp_res = 17'(int'(ea) + int'(eb) + int'(ec));
      checks++;
      if (bus.ain !== ea || bus.bin !== eb || bus.cin !== ec) begin
        errors++;
        $display("FAIL rand_%0d_operands got %h %h %b want %h %h %b",
                 f, bus.ain, bus.bin, bus.cin, ea, eb, ec);
      end
      wait_result(got, lat);
      checks++;
      if (got !== exp_res || lat !== LAT) begin
        errors++;
        $display("FAIL rand_%0d_result got %h lat=%0d want %h lat=%0d", f, got, lat, exp_res, LAT);
      end
      accept_result(int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.in_sof    = 1'b0;
    bus.in_cin    = 1'b0;
    bus.res_ready = 1'b0;
    test_reset();
    test_basic();
    test_vectors();
    test_backpressure();
    test_sof_resync();
    test_reset_in_wait();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
